key_expand: RTL and testbench

KEY_EXPAND -- requirements
Module: key_expand

---
 rtl/key_expand.sv | 185 ++++++++++++++++++
 tb/tb_key_expand.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_expand.sv
// key_expand: FIPS-197 AES-128/192/256 key schedule delivering one round key per handshake.
// Optional feature: define KEY_EXPAND_LAST_KEY_EN to add last_key/last_valid capture of the final round key.
module key_expand #(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [1:0]   key_len,
    input  logic [0:255] key,
    input  logic         ready,
    output logic [0:127] round_key,
    output logic         w_e,
    output logic [3:0]   round_no,
    output logic         busy,
    output logic         en_o,
    output logic         err
`ifdef KEY_EXPAND_LAST_KEY_EN
    ,
    output logic [0:127] last_key,
    output logic         last_valid
`endif
);
    localparam int WB = 32 * MAX_NK;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [0:WB-1] win_q, win_d;
    logic [3:0]    nk_q, nk_d, round_no_q, round_no_d;
    logic [2:0]    pos_q, pos_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          en_o_q, en_o_d, err_q, err_d;
`ifdef KEY_EXPAND_LAST_KEY_EN
    logic [0:127]  last_key_q, last_key_d;
    logic          last_valid_q, last_valid_d;
`endif

    logic [31:0]   gen [4];
    logic [31:0]   prev, t;
    logic [3:0]    idx, nk_sel;
    logic          rot_any;
    logic [0:WB-1] ins;
    logic [0:255]  key_m;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, v;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        v = gf_mul(r, r);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Next four schedule words; the window holds w[4N .. 4N+Nk-1], so w[i-1] is its last live word
    always_comb begin
        prev    = win_q[32*(nk_q-1) +: 32];
        t       = '0;
        idx     = '0;
        rot_any = 1'b0;
        for (int j = 0; j < 4; j++) begin
            idx = {1'b0, pos_q} + 4'(j);
            t   = prev;
            if (idx == 4'd0 || idx == nk_q) begin
                t       = sub_word({t[23:0], t[31:24]}) ^ {rcon_q, 24'h0};
                rot_any = 1'b1;
            end else if (nk_q == 4'd8 && idx == 4'd4) begin
                t = sub_word(t);
            end
            gen[j] = win_q[32*j +: 32] ^ t;
            prev   = gen[j];
        end
        ins        = '0;
        ins[0:127] = {gen[0], gen[1], gen[2], gen[3]};
    end

    // Accept/advance/finish decisions for the IDLE/RUN controller
    always_comb begin
        nk_sel     = key_len == 2'd0 ? 4'd4 : key_len == 2'd1 ? 4'd6 : 4'd8;
        key_m      = key & ~({256{1'b1}} >> (32 * nk_sel));
        state_d    = state_q;
        win_d      = win_q;
        nk_d       = nk_q;
        round_no_d = round_no_q;
        pos_d      = pos_q;
        rcon_d     = rcon_q;
        en_o_d     = 1'b0;
        err_d      = 1'b0;
`ifdef KEY_EXPAND_LAST_KEY_EN
        last_key_d   = last_key_q;
        last_valid_d = last_valid_q;
`endif
        if (state_q == IDLE && en) begin
            if (key_len == 2'b11 || nk_sel > 4'(MAX_NK)) begin
                err_d = 1'b1;
            end else begin
                state_d    = RUN;
                win_d      = key_m[0:WB-1];
                nk_d       = nk_sel;
                round_no_d = '0;
                pos_d      = '0;
                rcon_d     = 8'h01;
`ifdef KEY_EXPAND_LAST_KEY_EN
                last_valid_d = 1'b0;
`endif
            end
        end else if (state_q == RUN && ready) begin
            if (round_no_q == nk_q + 4'd6) begin
                state_d = IDLE;
                en_o_d  = 1'b1;
`ifdef KEY_EXPAND_LAST_KEY_EN
                last_key_d   = win_q[0:127];
                last_valid_d = 1'b1;
`endif
            end else begin
                round_no_d = round_no_q + 4'd1;
                win_d      = (win_q << 128) | (ins >> (32 * (nk_q - 4'd4)));
                pos_d      = nk_q == 4'd4 ? 3'd0 : nk_q == 4'd8 ? pos_q ^ 3'd4 :
                             pos_q >= 3'd2 ? pos_q - 3'd2 : pos_q + 3'd4;
                rcon_d     = rot_any ? xtime(rcon_q) : rcon_q;
            end
        end
    end

    // Controller and schedule registers; reset aborts any expansion in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            nk_q       <= 4'd4;
            round_no_q <= '0;
            pos_q      <= '0;
            rcon_q     <= 8'h01;
            en_o_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef KEY_EXPAND_LAST_KEY_EN
            last_key_q   <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            nk_q       <= nk_d;
            round_no_q <= round_no_d;
            pos_q      <= pos_d;
            rcon_q     <= rcon_d;
            en_o_q     <= en_o_d;
            err_q      <= err_d;
`ifdef KEY_EXPAND_LAST_KEY_EN
            last_key_q   <= last_key_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign round_key = win_q[0:127];
    assign w_e       = state_q == RUN;
    assign busy      = state_q == RUN;
    assign round_no  = round_no_q;
    assign en_o      = en_o_q;
    assign err       = err_q;
`ifdef KEY_EXPAND_LAST_KEY_EN
    assign last_key   = last_key_q;
    assign last_valid = last_valid_q;
`endif
endmodule

// File: tb/tb_key_expand.sv
// tb_key_expand: scoreboard bench for key_expand (default and MAX_NK=4 instances).
module tb_key_expand;
    localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0, reset_n = 1'b0, en = 1'b0, en4 = 1'b0, ready = 1'b1;
    logic [1:0]   key_len = 2'd0;
    logic [0:255] key = '0;
    logic [0:127] round_key, round_key4;
    logic         w_e, w_e4, busy, busy4, en_o, en_o4, err, err4;
    logic [3:0]   round_no, round_no4;
`ifdef KEY_EXPAND_LAST_KEY_EN
    logic [0:127] last_key, last_key4;
    logic         last_valid, last_valid4;
`endif

    int           n_assert = 0, n_fail = 0;
    logic [7:0]   sbt [256];
    logic [7:0]   rc [1:10];
    logic [31:0]  w [60];
    logic [131:0] sb [$];

    always #5 clk = ~clk;

    key_expand u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .key_len(key_len), .key(key), .ready(ready),
        .round_key(round_key), .w_e(w_e), .round_no(round_no), .busy(busy), .en_o(en_o), .err(err)
`ifdef KEY_EXPAND_LAST_KEY_EN
        , .last_key(last_key), .last_valid(last_valid)
`endif
    );

    key_expand #(.MAX_NK(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .en(en4), .key_len(key_len), .key(key), .ready(ready),
        .round_key(round_key4), .w_e(w_e4), .round_no(round_no4), .busy(busy4), .en_o(en_o4), .err(err4)
`ifdef KEY_EXPAND_LAST_KEY_EN
        , .last_key(last_key4), .last_valid(last_valid4)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (x != 0 && tmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbt[x] = b;
        end
    endtask

    task automatic expand(input logic [0:255] k, input int nk);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
            else if (nk == 8 && i % 8 == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
    endtask

    // Called at a negedge; returns at the negedge of the en_o cycle.
    task automatic run(input logic [0:255] k, input logic [1:0] kl, input int nk, input bit rnd,
                       input bit poke, input logic [127:0] kat, input string nm);
        int nr, cyc;
        bit stalled;
        logic [127:0] pk;
        logic [3:0] pr;
        logic [131:0] f;
        nr = nk + 6;
        expand(k, nk);
        sb.delete();
        for (int r = 0; r <= nr; r++) sb.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        key = k; key_len = kl; en = 1'b1; ready = 1'b1;
        @(negedge clk);
        en = 1'b0; key = '1; key_len = 2'b11;
        cyc = 0; stalled = 1'b0; pk = '0; pr = '0;
        while (sb.size() > 0 && cyc < 300) begin
            f = sb[0];
            check({nm, " w_e"}, 128'(w_e), 128'(1));
            check({nm, " busy"}, 128'(busy), 128'(1));
            check({nm, " err"}, 128'(err), 128'(0));
            check({nm, " round_no"}, 128'(round_no), 128'(f[131:128]));
            check({nm, " round_key"}, 128'(round_key), f[127:0]);
`ifdef KEY_EXPAND_LAST_KEY_EN
            if (cyc == 0) check({nm, " last_valid_clr"}, 128'(last_valid), 128'(0));
`endif
            if (stalled) begin
                check({nm, " stall_key"}, 128'(round_key), pk);
                check({nm, " stall_no"}, 128'(round_no), 128'(pr));
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            en = poke && cyc == 3;
            if (ready) begin
                void'(sb.pop_front());
                if (f[131:128] == 4'(nr)) check({nm, " kat"}, 128'(round_key), kat);
            end
            stalled = !ready; pk = round_key; pr = round_no; cyc++;
            @(negedge clk);
        end
        en = 1'b0; ready = 1'b1;
        check({nm, " budget"}, 128'(sb.size()), 128'(0));
        check({nm, " en_o"}, 128'(en_o), 128'(1));
        check({nm, " w_e_off"}, 128'(w_e), 128'(0));
        check({nm, " busy_off"}, 128'(busy), 128'(0));
`ifdef KEY_EXPAND_LAST_KEY_EN
        check({nm, " last_key"}, 128'(last_key), kat);
        check({nm, " last_valid"}, 128'(last_valid), 128'(1));
`endif
    endtask

    initial begin
        int cyc;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        build_sbox();
        repeat (2) @(negedge clk);
        check("rst round_key", 128'(round_key), 128'(0));
        check("rst round_no", 128'(round_no), 128'(0));
        check("rst w_e", 128'(w_e), 128'(0));
        check("rst busy", 128'(busy), 128'(0));
        check("rst en_o", 128'(en_o), 128'(0));
        check("rst err", 128'(err), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        run(K128, 2'd0, 4, 1'b0, 1'b0, R128, "aes128");
        run(K192, 2'd1, 6, 1'b0, 1'b0, R192, "aes192");
        run(K256, 2'd2, 8, 1'b0, 1'b0, R256, "aes256");
        @(negedge clk);
        check("done en_o_pulse", 128'(en_o), 128'(0));
        check("done w_e", 128'(w_e), 128'(0));
`ifdef KEY_EXPAND_LAST_KEY_EN
        check("hold last_valid", 128'(last_valid), 128'(1));
        check("hold last_key", 128'(last_key), R256);
`endif
        run(K128, 2'd0, 4, 1'b1, 1'b1, R128, "aes128_bp");
        @(negedge clk);
        key_len = 2'b11; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("illegal err", 128'(err), 128'(1));
        check("illegal w_e", 128'(w_e), 128'(0));
        check("illegal busy", 128'(busy), 128'(0));
        @(negedge clk);
        check("illegal err_pulse", 128'(err), 128'(0));
        check("illegal w_e2", 128'(w_e), 128'(0));
        key = K256; key_len = 2'd2; en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        check("nk4 err", 128'(err4), 128'(1));
        check("nk4 w_e", 128'(w_e4), 128'(0));
        check("nk4 busy", 128'(busy4), 128'(0));
        @(negedge clk);
        check("nk4 err_pulse", 128'(err4), 128'(0));
        check("nk4 w_e2", 128'(w_e4), 128'(0));
        key = K128; key_len = 2'd0; en = 1'b1; ready = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        while (round_no != 4'd5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("midrun round_no", 128'(round_no), 128'(5));
        reset_n = 1'b0;
        #1;
        check("arst round_key", 128'(round_key), 128'(0));
        check("arst round_no", 128'(round_no), 128'(0));
        check("arst w_e", 128'(w_e), 128'(0));
        check("arst busy", 128'(busy), 128'(0));
        check("arst en_o", 128'(en_o), 128'(0));
        check("arst err", 128'(err), 128'(0));
`ifdef KEY_EXPAND_LAST_KEY_EN
        check("arst last_key", 128'(last_key), 128'(0));
        check("arst last_valid", 128'(last_valid), 128'(0));
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(K128, 2'd0, 4, 1'b0, 1'b0, R128, "aes128_rst");
        @(negedge clk);
        check("final en_o", 128'(en_o), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
